// File: rtl/mem_seq.sv
// mem_seq: LC-3b address/memory-access sequencer (EAB selects, MAR capture, one handshaked access).
// Optional macro ALIGN_CHECK_EN: odd-address LDW/STW fault in WB instead of accessing memory.
module mem_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic [15:0] st_data,
    input  logic        br_taken,
    input  logic [15:0] ea,
    output logic        addr1_sel,
    output logic [1:0]  addr2_sel,
    output logic        lshf1,
    output logic [15:0] mar,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mdr_in,
    output logic [15:0] rd_data,
    output logic        ld_reg,
    output logic        ld_pc,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    typedef enum logic [1:0] {StIdle, StCalc, StMem, StWb} state_e;
    typedef enum logic [2:0] {
        OpNone, OpBr, OpLdb, OpStb, OpLdw, OpStw, OpJump, OpLea
    } op_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d, dec_op;
    logic        dec_a1;
    logic [1:0]  dec_a2;
    logic        addr1_q, addr1_d;
    logic [1:0]  addr2_q, addr2_d;
    logic [15:0] st_q, st_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] rd_q, rd_d;
    logic        taken_q, taken_d;
    logic        is_store, is_byte, is_load;
    logic        fault_wb;

    // Only the opcode and the JSR/JSRR bit steer this block; the offsets go to the EAB directly.
    logic unused_ir;
    assign unused_ir = ^ir[10:0];

    always_comb begin
        dec_op = OpNone;
        dec_a1 = 1'b0;
        dec_a2 = 2'd0;
        case (ir[15:12])
            4'b0000: begin dec_op = OpBr;  dec_a1 = 1'b0; dec_a2 = 2'd2; end
            4'b0010: begin dec_op = OpLdb; dec_a1 = 1'b1; dec_a2 = 2'd1; end
            4'b0011: begin dec_op = OpStb; dec_a1 = 1'b1; dec_a2 = 2'd1; end
            4'b0110: begin dec_op = OpLdw; dec_a1 = 1'b1; dec_a2 = 2'd1; end
            4'b0111: begin dec_op = OpStw; dec_a1 = 1'b1; dec_a2 = 2'd1; end
            4'b0100: begin
                dec_op = OpJump;
                if (ir[11]) begin
                    dec_a1 = 1'b0;
                    dec_a2 = 2'd3;
                end else begin
                    dec_a1 = 1'b1;
                    dec_a2 = 2'd0;
                end
            end
            4'b1100: begin dec_op = OpJump; dec_a1 = 1'b1; dec_a2 = 2'd0; end
            4'b1110: begin dec_op = OpLea;  dec_a1 = 1'b0; dec_a2 = 2'd2; end
            default: ;
        endcase
    end

    assign is_store = (op_q == OpStb) || (op_q == OpStw);
    assign is_byte  = (op_q == OpLdb) || (op_q == OpStb);
    assign is_load  = (op_q == OpLdb) || (op_q == OpLdw);

`ifdef ALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign fault_wb = fault_q;
`else
    assign fault_wb = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        st_d    = st_q;
        mar_d   = mar_q;
        rd_d    = rd_q;
        taken_d = taken_q;
`ifdef ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = dec_op;
                    addr1_d = dec_a1;
                    addr2_d = dec_a2;
                    st_d    = st_data;
                    taken_d = 1'b0;
`ifdef ALIGN_CHECK_EN
                    fault_d = 1'b0;
`endif
                    state_d = (dec_op == OpNone) ? StWb : StCalc;
                end
            end
            StCalc: begin
                mar_d   = ea;
                state_d = StWb;
                unique case (op_q)
                    OpLdb, OpStb, OpLdw, OpStw: state_d = StMem;
                    OpBr: begin
                        rd_d    = ea;
                        taken_d = br_taken;
                    end
                    OpJump, OpLea: rd_d = ea;
                    default: ;
                endcase
`ifdef ALIGN_CHECK_EN
                if (((op_q == OpLdw) || (op_q == OpStw)) && ea[0]) begin
                    fault_d = 1'b1;
                    state_d = StWb;
                end
`endif
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = StWb;
                    if (op_q == OpLdw) begin
                        rd_d = mdr_in;
                    end else if (op_q == OpLdb) begin
                        // Odd byte address selects the high lane.
                        rd_d = mar_q[0] ? {{8{mdr_in[15]}}, mdr_in[15:8]}
                                        : {{8{mdr_in[7]}}, mdr_in[7:0]};
                    end
                end
            end
            StWb: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpNone;
            addr1_q <= 1'b0;
            addr2_q <= 2'd0;
            st_q    <= 16'h0000;
            mar_q   <= 16'h0000;
            rd_q    <= 16'h0000;
            taken_q <= 1'b0;
`ifdef ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            st_q    <= st_d;
            mar_q   <= mar_d;
            rd_q    <= rd_d;
            taken_q <= taken_d;
`ifdef ALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    // Strobes decode from state only, so an asynchronous reset drops them at once.
    always_comb begin
        busy      = (state_q != StIdle);
        mem_en    = (state_q == StMem);
        mem_we    = mem_en && is_store;
        mem_byte  = mem_en && is_byte;
        mem_wdata = 16'h0000;
        if (mem_en) begin
            mem_wdata = is_byte ? {st_q[7:0], st_q[7:0]} : st_q;
        end
        done   = (state_q == StWb);
        fault  = done && fault_wb;
        ld_reg = done && !fault_wb && (is_load || (op_q == OpLea));
        ld_pc  = done && ((op_q == OpJump) || ((op_q == OpBr) && taken_q));
    end

    assign addr1_sel = addr1_q;
    assign addr2_sel = addr2_q;
    assign lshf1     = 1'b0;
    assign mar       = mar_q;
    assign rd_data   = rd_q;

endmodule

// File: tb/tb_mem_seq.sv
// Directed, table-driven bench for mem_seq; define ALIGN_CHECK_EN to match an aligned-check build.
module tb_mem_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ir, st_data, ea, mdr_in;
    logic        br_taken, mem_ready;
    logic        addr1_sel, lshf1, mem_en, mem_we, mem_byte;
    logic [1:0]  addr2_sel;
    logic [15:0] mar, mem_wdata, rd_data;
    logic        ld_reg, ld_pc, busy, done, fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ir        (ir),
        .st_data   (st_data),
        .br_taken  (br_taken),
        .ea        (ea),
        .addr1_sel (addr1_sel),
        .addr2_sel (addr2_sel),
        .lshf1     (lshf1),
        .mar       (mar),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mdr_in    (mdr_in),
        .rd_data   (rd_data),
        .ld_reg    (ld_reg),
        .ld_pc     (ld_pc),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    typedef struct {
        logic [15:0] ir;
        logic [15:0] st;
        logic [15:0] ea;
        logic        br;
        logic [15:0] mdr;
        int          dly;      // MEM wait cycles before mem_ready
        logic        spam;     // hold start high while busy
        logic        chk_sel;
        logic        a1;
        logic [1:0]  a2;
        int          lat;      // cycles from accept edge to done
        int          en_cyc;
        logic        we;
        logic        byt;
        logic [15:0] wdata;
        logic [15:0] rd;
        logic        ld_reg;
        logic        ld_pc;
        logic        flt;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {6'd0, mar, rd_data, mem_wdata, addr1_sel, addr2_sel, lshf1, mem_en, mem_we,
                mem_byte, ld_reg, ld_pc, busy, done, fault};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int   cyc;
        int   mcnt;
        logic seen_done;
        @(negedge clk);
        ir        = v.ir;
        st_data   = v.st;
        ea        = v.ea;
        br_taken  = v.br;
        start     = 1'b1;
        mem_ready = 1'b1;      // must be ignored outside MEM
        mdr_in    = ~v.mdr;
        @(negedge clk);
        start     = v.spam;
        cyc       = 1;
        mcnt      = 0;
        seen_done = 1'b0;
        if (v.chk_sel) chk($sformatf("v%0d_sel", idx), {addr1_sel, addr2_sel, lshf1},
                           {v.a1, v.a2, 1'b0});
        while (!seen_done && cyc <= 30) begin
            if (mem_en) begin
                chk($sformatf("v%0d_mar", idx), mar, v.ea);
                chk($sformatf("v%0d_we_byte", idx), {mem_we, mem_byte}, {v.we, v.byt});
                chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
                mem_ready = (mcnt == v.dly);
                mdr_in    = (mcnt == v.dly) ? v.mdr : ~v.mdr;
                mcnt++;
            end else begin
                mem_ready = 1'b1;
            end
            if (done) begin
                seen_done = 1'b1;
                chk($sformatf("v%0d_latency", idx), cyc, v.lat);
                chk($sformatf("v%0d_mem_cycles", idx), mcnt, v.en_cyc);
                chk($sformatf("v%0d_pulses", idx), {ld_reg, ld_pc, fault},
                    {v.ld_reg, v.ld_pc, v.flt});
                chk($sformatf("v%0d_rd_data", idx), rd_data, v.rd);
            end else begin
                chk($sformatf("v%0d_pulse_early", idx), {ld_reg, ld_pc, fault}, 3'b000);
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("v%0d_no_timeout", idx), seen_done, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_back_idle", idx), {busy, done, mem_en}, 3'b000);
    endtask

    initial begin
        //            ir        st        ea        br    mdr       dly spm sel a1    a2    lat en we    byt   wdata     rd        ldr   ldp   flt
        vecs[0]  = '{16'hE005, 16'h0000, 16'h3010, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 2'd2, 2, 0, 1'b0, 1'b0, 16'h0000, 16'h3010, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'h6042, 16'h1111, 16'h4000, 1'b0, 16'hBEEF, 3, 1'b0, 1'b1, 1'b1, 2'd1, 6, 4, 1'b0, 1'b0, 16'h1111, 16'hBEEF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'h2042, 16'h0000, 16'h4001, 1'b0, 16'h80FF, 0, 1'b0, 1'b1, 1'b1, 2'd1, 3, 1, 1'b0, 1'b1, 16'h0000, 16'hFF80, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h2042, 16'h0000, 16'h4002, 1'b0, 16'h807F, 1, 1'b0, 1'b1, 1'b1, 2'd1, 4, 2, 1'b0, 1'b1, 16'h0000, 16'h007F, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'h3042, 16'h12A5, 16'h4003, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b1, 2'd1, 3, 1, 1'b1, 1'b1, 16'hA5A5, 16'h007F, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h7042, 16'h5A3C, 16'h4004, 1'b0, 16'h0000, 2, 1'b0, 1'b1, 1'b1, 2'd1, 5, 3, 1'b1, 1'b0, 16'h5A3C, 16'h007F, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h0E05, 16'h0000, 16'h3020, 1'b0, 16'h0000, 0, 1'b1, 1'b1, 1'b0, 2'd2, 2, 0, 1'b0, 1'b0, 16'h0000, 16'h3020, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h0E05, 16'h0000, 16'h3030, 1'b1, 16'h0000, 0, 1'b1, 1'b1, 1'b0, 2'd2, 2, 0, 1'b0, 1'b0, 16'h0000, 16'h3030, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'h4805, 16'h0000, 16'h5000, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 2'd3, 2, 0, 1'b0, 1'b0, 16'h0000, 16'h5000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'h4080, 16'h0000, 16'h6000, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b1, 2'd0, 2, 0, 1'b0, 1'b0, 16'h0000, 16'h6000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'hC1C0, 16'h0000, 16'h7000, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b1, 2'd0, 2, 0, 1'b0, 1'b0, 16'h0000, 16'h7000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'h1042, 16'h0000, 16'h1234, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 2'd0, 1, 0, 1'b0, 1'b0, 16'h0000, 16'h7000, 1'b0, 1'b0, 1'b0};
`ifdef ALIGN_CHECK_EN
        vecs[12] = '{16'h6042, 16'h0000, 16'h4001, 1'b0, 16'h1357, 0, 1'b0, 1'b1, 1'b1, 2'd1, 2, 0, 1'b0, 1'b0, 16'h0000, 16'h7000, 1'b0, 1'b0, 1'b1};
`else
        vecs[12] = '{16'h6042, 16'h0000, 16'h4001, 1'b0, 16'h1357, 0, 1'b0, 1'b1, 1'b1, 2'd1, 3, 1, 1'b0, 1'b0, 16'h0000, 16'h1357, 1'b1, 1'b0, 1'b0};
`endif

        // Reset held with random inputs: every output stays zero.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start     = 1'($urandom);
            ir        = 16'($urandom);
            st_data   = 16'($urandom);
            br_taken  = 1'($urandom);
            ea        = 16'($urandom);
            mem_ready = 1'($urandom);
            mdr_in    = 16'($urandom);
            #1 chk($sformatf("reset_outs_%0d", i), all_outs(), 64'd0);
        end
        @(negedge clk);
        start     = 1'b0;
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Reset in the second MEM cycle abandons the access with no done.
        @(negedge clk);
        ir        = 16'h6042;
        ea        = 16'h4000;
        mem_ready = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_before", {busy, mem_en}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk("rst_mem_en_drop", all_outs(), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            chk($sformatf("rst_no_done_%0d", i), all_outs(), 64'd0);
        end
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        run_vec(20, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_seq.md
# mem_seq

Address/memory-access sequencer for the LC-3b datapath. It decodes the latched instruction, drives the effective-address adder's select lines, captures the computed address into MAR and runs one handshaked memory access (load or store), then hands the result back to the register file or PC. It sits between the control unit (start/done) and the EAB plus memory port.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  begin operation; accepted only in IDLE
- ir  in  16  instruction, captured on accepted start
- st_data  in  16  store source value, captured on accepted start
- br_taken  in  1  external nzp/cc match, sampled in CALC
- ea  in  16  EAB result, combinational from addr1_sel/addr2_sel/lshf1
- addr1_sel  out  1  EAB base select (0 = PC, 1 = register)
- addr2_sel  out  2  EAB offset select (0 = zero, 1 = off6, 2 = off9, 3 = off11)
- lshf1  out  1  EAB base-shift control, held 0
- mar  out  16  memory address register
- mem_en  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_en
- mem_byte  out  1  byte access, valid with mem_en
- mem_wdata  out  16  store data
- mem_ready  in  1  memory completion
- mdr_in  in  16  read data, valid when mem_ready
- rd_data  out  16  load result or LEA/branch target
- ld_reg  out  1  one-cycle register-write pulse
- ld_pc  out  1  one-cycle PC-load pulse
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  alignment fault, valid with done

## Operation
- States: IDLE, CALC, MEM, WB.
- IDLE + start: latch ir and st_data. Set addr1_sel/addr2_sel from the opcode. Go to CALC.
- Unsupported opcode: go straight to WB. done is the only pulse.
- Select lines are registered. They load on start and hold until the next start.
- Opcode decode (ir[15:12]):
  - BR 0000: addr1 = 0, addr2 = 2.
  - LDB 0010, STB 0011, LDW 0110, STW 0111: addr1 = 1, addr2 = 1.
  - JSR 0100 with ir[11] = 1: addr1 = 0, addr2 = 3.
  - JSRR 0100 with ir[11] = 0, and JMP 1100: addr1 = 1, addr2 = 0.
  - LEA 1110: addr1 = 0, addr2 = 2.
- CALC: mar <= ea.
  - Loads/stores go to MEM.
  - LEA: rd_data <= ea.
  - BR: rd_data <= ea; ld_pc fires in WB only if br_taken was high in CALC.
  - JSR/JSRR/JMP: rd_data <= ea; ld_pc always fires.
  - Non-memory ops go to WB.
- MEM: mem_en = 1 and mem_we = store.
  - mem_byte = 1 for LDB/STB.
  - mem_wdata = st_data for word ops, {st_data[7:0], st_data[7:0]} for byte ops.
  - Stay in MEM until mem_ready is sampled high, then go to WB.
  - On that edge, load rd_data with:
    - word load: mdr_in;
    - byte load: sign-extended mdr_in[15:8] if mar[0] = 1, else mdr_in[7:0].
- WB: done = 1. ld_reg = 1 for loads and LEA. ld_pc as above. Stores pulse done only. Return to IDLE.
- JSR link register write is the datapath's job; ld_reg is not asserted.

## Timing
- Reset: state = IDLE. Every output is 0: mar, rd_data, mem_wdata, addr1_sel, addr2_sel, lshf1, mem_en, mem_we, mem_byte, ld_reg, ld_pc, busy, done, fault.
- Reset acts asynchronously. Asserting rst_n mid-MEM drops mem_en immediately. The access is abandoned and no done pulse is produced.
- Latency with start accepted at edge T:
  - non-memory: done high during T+2;
  - memory with mem_ready on the first MEM cycle: done during T+3; each wait cycle adds 1.
  - unsupported opcode: done during T+1.
- start while busy is ignored, including start in the WB cycle. Back-to-back: the earliest next accept is the cycle after WB.
- mar, mem_we, mem_byte and mem_wdata are stable for the whole MEM interval.
- mem_ready outside MEM is ignored.
- rd_data holds until overwritten by a later LEA/branch/load.

## Configuration
- ALIGN_CHECK_EN defined:
  - LDW/STW with ea[0] = 1 in CALC skips MEM and goes to WB.
  - In WB: done = 1 and fault = 1. No ld_reg and no memory access.
  - fault is a one-cycle pulse.
- ALIGN_CHECK_EN undefined: no check. fault is tied 0. Odd word addresses are issued unchanged.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> all outputs 0, busy = 0. Release, then start LEA ir = 16'hE005, ea = 16'h3010 -> addr1_sel = 0, addr2_sel = 2, done and ld_reg during T+2, rd_data = 16'h3010.
- LDW: ir = 16'h6042, ea = 16'h4000, mem_ready delayed 3 cycles, mdr_in = 16'hBEEF -> mem_en held 4 cycles, mar = 16'h4000, rd_data = 16'hBEEF, ld_reg = 1, done at T+6.
- LDB, odd address: ea = 16'h4001, mdr_in = 16'h80FF -> mem_byte = 1, rd_data = 16'hFF80.
- STB: st_data = 16'h12A5 -> mem_we = 1, mem_byte = 1, mem_wdata = 16'hA5A5, done without ld_reg.
- BR: br_taken = 0 -> done, no ld_pc. br_taken = 1 -> ld_pc, rd_data = ea. Extra start pulses while busy are ignored.
- Reset in MEM cycle 2 -> mem_en falls the same cycle, no done pulse. With ALIGN_CHECK_EN, LDW at ea = 16'h4001 -> fault = 1 and done at T+2, mem_en never asserted.
